// File: rtl/adcemu_tx_pkg.sv
// Shared constants for the synthetic ADC transmitter: pattern numbers, FSM
// encoding, frame/train words and the PRBS LFSR definition.
package adcemu_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } adc_state_e;

  localparam logic [3:0] PAT_ZERO  = 4'd0;
  localparam logic [3:0] PAT_ZERO1 = 4'd1;
  localparam logic [3:0] PAT_ONES  = 4'd2;
  localparam logic [3:0] PAT_CKB   = 4'd3;
  localparam logic [3:0] PAT_RAMP  = 4'd4;
  localparam logic [3:0] PAT_CONST = 4'd5;
  localparam logic [3:0] PAT_PRBS  = 4'd6;

  localparam int         TRAIN_LEN  = 16;
  localparam logic [5:0] FRAME_WORD = 6'b111000;
  localparam logic [11:0] TRAIN_WORD = 12'hFC0;
  localparam logic [11:0] CKB_A      = 12'hAAA;
  localparam logic [11:0] CKB_B      = 12'h555;
  localparam logic [11:0] CONST_WORD = 12'h03F;

  // x^12+x^6+x^4+x+1: feedback from state bits 11, 5, 3 and 0
  localparam logic [11:0] LFSR_SEED = 12'hFFF;
  localparam logic [11:0] LFSR_TAPS = 12'h829;

  function automatic logic [11:0] lfsr_step(input logic [11:0] s);
    return {s[10:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/adcemu_slip.sv
// One lane's bit slip: selects a 6-bit window out of {current, previous} raw
// words. Slip values 6 and 7 behave as 0.
module adcemu_slip (
  input  logic       CLK,
  input  logic       chk_rst,
  input  logic [5:0] raw,
  input  logic [2:0] slip,
  output logic [5:0] slipped
);

  logic [5:0]  prev_r;
  logic [11:0] win_s;

  // previous raw word of this lane
  always_ff @(posedge CLK or posedge chk_rst) begin
    if (chk_rst) prev_r <= 6'd0;
    else         prev_r <= raw;
  end

  // window select
  always_comb begin
    win_s = {raw, prev_r};
    case (slip)
      3'd1:    slipped = win_s[6:1];
      3'd2:    slipped = win_s[7:2];
      3'd3:    slipped = win_s[8:3];
      3'd4:    slipped = win_s[9:4];
      3'd5:    slipped = win_s[10:5];
      default: slipped = raw;
    endcase
  end

endmodule

// File: rtl/adcemu_tx.sv
// Synthetic ADC transmitter: IDLE/TRAIN/RUN sequencer, test patterns, per-lane
// slip and single-bit error injection. Define ADCEMU_PRBS_EN to build PRBS (type 6).
module adcemu_tx
  import adcemu_tx_pkg::*;
(
  input  logic        CLK,
  input  logic        chk_rst,
  input  logic        enb,
  input  logic [3:0]  chk_type,
  input  logic [2:0]  slip,
  input  logic        err_inj,
  input  logic [1:0]  err_ch,
  output logic [47:0] DOUT,
  output logic [5:0]  FR,
  output logic [1:0]  state,
  output logic [15:0] inj_cnt
);

  adc_state_e  state_r, state_nxt_s;
  logic [3:0]  train_cnt_r, type_r;
  logic [11:0] ramp_r, ramp_val_s;
  logic        ckb_r, ckb_val_s, restart_s, inj_s;
  logic [11:0] pat_s, chan_s;
  logic [5:0]  fr_raw_s;
  logic [5:0]  raw_s [9];
  logic [5:0]  slip_o_s [9];
  logic [47:0] dout_s, mask_s;
`ifdef ADCEMU_PRBS_EN
  logic [11:0] lfsr_r, lfsr_val_s;
`endif

  assign state = state_r;

  // next state, pattern selection and raw lane words for the next output word
  always_comb begin
    state_nxt_s = state_r;
    if (!enb) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE:  state_nxt_s = ST_TRAIN;
        ST_TRAIN: state_nxt_s = (train_cnt_r == 4'(TRAIN_LEN - 1)) ? ST_RUN : ST_TRAIN;
        ST_RUN:   state_nxt_s = ST_RUN;
        default:  state_nxt_s = ST_IDLE;
      endcase
    end

    // entering RUN or switching pattern restarts the generators on this word
    restart_s  = (state_r != ST_RUN) || (chk_type != type_r);
    ramp_val_s = restart_s ? 12'h000 : ramp_r;
    ckb_val_s  = restart_s ? 1'b0 : ckb_r;
`ifdef ADCEMU_PRBS_EN
    lfsr_val_s = restart_s ? LFSR_SEED : lfsr_r;
`endif

    case (chk_type)
      PAT_ONES:  pat_s = 12'hFFF;
      PAT_CKB:   pat_s = ckb_val_s ? CKB_B : CKB_A;
      PAT_RAMP:  pat_s = ramp_val_s;
      PAT_CONST: pat_s = CONST_WORD;
`ifdef ADCEMU_PRBS_EN
      PAT_PRBS:  pat_s = lfsr_val_s;
`else
      PAT_PRBS:  pat_s = 12'h000;
`endif
      default:   pat_s = 12'h000;
    endcase

    case (state_nxt_s)
      ST_TRAIN: begin chan_s = TRAIN_WORD; fr_raw_s = FRAME_WORD; end
      ST_RUN:   begin chan_s = pat_s;      fr_raw_s = FRAME_WORD; end
      default:  begin chan_s = 12'h000;    fr_raw_s = 6'b000000;  end
    endcase

    for (int k = 0; k < 8; k++) begin
      raw_s[k] = (k % 2 == 1) ? chan_s[11:6] : chan_s[5:0];
    end
    raw_s[8] = fr_raw_s;
  end

  for (genvar g = 0; g < 9; g++) begin : g_lane
    adcemu_slip u_slip (
      .CLK     (CLK),
      .chk_rst (chk_rst),
      .raw     (raw_s[g]),
      .slip    (slip),
      .slipped (slip_o_s[g])
    );
  end

  // slipped data lanes and the error mask applied on top of them
  always_comb begin
    dout_s = 48'h0;
    for (int k = 0; k < 8; k++) begin
      dout_s[6*k +: 6] = slip_o_s[k];
    end
    inj_s = err_inj && (state_r == ST_RUN);
    if (inj_s) begin
      case (err_ch)
        2'd0:    mask_s = 48'h000000000001;
        2'd1:    mask_s = 48'h000000001000;
        2'd2:    mask_s = 48'h000001000000;
        2'd3:    mask_s = 48'h001000000000;
        default: mask_s = 48'h000000000000;
      endcase
    end else begin
      mask_s = 48'h000000000000;
    end
  end

  // sequencer and pattern generator state
  always_ff @(posedge CLK or posedge chk_rst) begin
    if (chk_rst) begin
      state_r     <= ST_IDLE;
      train_cnt_r <= 4'd0;
      type_r      <= 4'd0;
      ramp_r      <= 12'h000;
      ckb_r       <= 1'b0;
`ifdef ADCEMU_PRBS_EN
      lfsr_r      <= LFSR_SEED;
`endif
    end else begin
      state_r     <= state_nxt_s;
      train_cnt_r <= (state_r == ST_TRAIN && state_nxt_s == ST_TRAIN) ? train_cnt_r + 4'd1 : 4'd0;
      type_r      <= chk_type;
      ramp_r      <= ramp_val_s + 12'h001;
      ckb_r       <= ~ckb_val_s;
`ifdef ADCEMU_PRBS_EN
      lfsr_r      <= lfsr_step(lfsr_val_s);
`endif
    end
  end

  // registered outputs
  always_ff @(posedge CLK or posedge chk_rst) begin
    if (chk_rst) begin
      DOUT    <= 48'h0;
      FR      <= 6'b000000;
      inj_cnt <= 16'h0000;
    end else begin
      DOUT <= dout_s ^ mask_s;
      FR   <= slip_o_s[8];
      if (inj_s && inj_cnt != 16'hFFFF) inj_cnt <= inj_cnt + 16'h0001;
    end
  end

endmodule

// File: tb/tb_adcemu_tx.sv
// Directed bench for adcemu_tx: train sequence, ramp wrap, checkerboard,
// slip, error injection, PRBS/zero for type 6 and asynchronous reset.
module tb_adcemu_tx;

  logic        CLK = 1'b0;
  logic        chk_rst, enb, err_inj;
  logic [3:0]  chk_type;
  logic [2:0]  slip;
  logic [1:0]  err_ch;
  logic [47:0] DOUT;
  logic [5:0]  FR;
  logic [1:0]  state;
  logic [15:0] inj_cnt;

  int vec_cnt = 0;
  int miscmp_cnt = 0;

  always #4 CLK = ~CLK;

  adcemu_tx dut (
    .CLK      (CLK),
    .chk_rst  (chk_rst),
    .enb      (enb),
    .chk_type (chk_type),
    .slip     (slip),
    .err_inj  (err_inj),
    .err_ch   (err_ch),
    .DOUT     (DOUT),
    .FR       (FR),
    .state    (state),
    .inj_cnt  (inj_cnt)
  );

  task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscmp_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [47:0] rep4(input logic [11:0] v);
    return {v, v, v, v};
  endfunction

  function automatic logic [11:0] prbs_next(input logic [11:0] m);
    return {m[10:0], m[11] ^ m[5] ^ m[3] ^ m[0]};
  endfunction

  initial begin
    logic [11:0] m;
    int zeros;
    chk_rst = 1'b1; enb = 1'b1; chk_type = 4'd4; slip = 3'd0;
    err_inj = 1'b0; err_ch = 2'd0;
    #18;
    chk("rst_dout", DOUT, 48'h0);
    chk("rst_fr", {42'h0, FR}, 48'h0);
    chk("rst_state", {46'h0, state}, 48'h0);
    chk("rst_inj", {32'h0, inj_cnt}, 48'h0);
    #4 chk_rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      tick();
      chk("train_state", {46'h0, state}, 48'd1);
      chk("train_dout", DOUT, 48'hFC0FC0FC0FC0);
      chk("train_fr", {42'h0, FR}, 48'h38);
    end

    // ramp: word k carries k mod 4096
    for (int k = 0; k <= 4096; k++) begin
      tick();
      if (k == 0) chk("run_state", {46'h0, state}, 48'd2);
      if (k < 3 || k == 4095 || k == 4096) chk("ramp", DOUT, rep4(12'(k)));
    end
    chk("run_fr", {42'h0, FR}, 48'h38);

    chk_type = 4'd3;
    tick(); chk("ckb0", DOUT, rep4(12'hAAA));
    tick(); chk("ckb1", DOUT, rep4(12'h555));
    tick(); chk("ckb2", DOUT, rep4(12'hAAA));

    chk_type = 4'd2; slip = 3'd2;
    tick();
    tick(); chk("slip_ones", DOUT, rep4(12'hFFF));
    chk("slip_fr", {42'h0, FR}, 48'h0E);
    tick(); chk("slip_fr2", {42'h0, FR}, 48'h0E);

    slip = 3'd0; chk_type = 4'd5; err_ch = 2'd2;
    tick(); chk("const", DOUT, rep4(12'h03F));
    err_inj = 1'b1; tick(); err_inj = 1'b0;
    chk("inj_a", DOUT, 48'h03F03E03F03F);
    tick(); chk("inj_a_clean", DOUT, rep4(12'h03F));
    err_inj = 1'b1; tick(); err_inj = 1'b0;
    chk("inj_b", DOUT, 48'h03F03E03F03F);
    tick(); chk("inj_b_clean", DOUT, rep4(12'h03F));
    chk("inj_cnt2", {32'h0, inj_cnt}, 48'd2);

    err_ch = 2'd0; err_inj = 1'b1;
    tick(); chk("b2b_0", DOUT, 48'h03F03F03F03E);
    tick(); chk("b2b_1", DOUT, 48'h03F03F03F03E);
    err_inj = 1'b0;
    tick(); chk("b2b_clean", DOUT, rep4(12'h03F));
    chk("inj_cnt4", {32'h0, inj_cnt}, 48'd4);

    enb = 1'b0;
    tick(); chk("idle_state", {46'h0, state}, 48'd0);
    chk("idle_dout", DOUT, 48'h0);
    chk("idle_fr", {42'h0, FR}, 48'h0);
    err_inj = 1'b1; tick(); err_inj = 1'b0;
    chk("idle_inj_dout", DOUT, 48'h0);
    chk("idle_inj_cnt", {32'h0, inj_cnt}, 48'd4);

    // type 6 after a fresh train
    enb = 1'b1; chk_type = 4'd6;
    for (int i = 0; i < 16; i++) tick();
`ifdef ADCEMU_PRBS_EN
    m = 12'hFFF; zeros = 0;
    for (int k = 0; k <= 4095; k++) begin
      tick();
      if (DOUT[11:0] == 12'h000) zeros++;
      if (k < 4 || k == 4095) chk("prbs", DOUT, rep4(m));
      if (k > 0 && k < 4095 && DOUT[11:0] == 12'hFFF) chk("prbs_period", {36'h0, DOUT[11:0]}, 48'h0);
      m = prbs_next(m);
    end
    chk("prbs_nozero", 48'(zeros), 48'd0);
`else
    m = 12'h000; zeros = 0;
    for (int k = 0; k < 4; k++) begin
      tick(); chk("prbs_off", DOUT, rep4(m));
      zeros++;
    end
`endif
    chk("pre_rst_state", {46'h0, state}, 48'd2);

    chk_rst = 1'b1;
    #1;
    chk("async_dout", DOUT, 48'h0);
    chk("async_fr", {42'h0, FR}, 48'h0);
    chk("async_inj", {32'h0, inj_cnt}, 48'h0);
    chk("async_state", {46'h0, state}, 48'd0);
    #1 chk_rst = 1'b0;
    tick(); chk("retrain_state", {46'h0, state}, 48'd1);
    chk("retrain_dout", DOUT, 48'hFC0FC0FC0FC0);

    // enb drop inside TRAIN restarts the full train
    for (int i = 0; i < 5; i++) tick();
    enb = 1'b0; tick(); enb = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (i == 15) chk("retrain_full", {46'h0, state}, 48'd1);
    end
    tick(); chk("retrain_run", {46'h0, state}, 48'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
    $finish;
  end

endmodule

// File: doc/adcemu_tx.md
# adcemu_tx

Synthetic ADC transmitter for loopback and self-test of the channel FPGA receive path. It generates four 12-bit test-pattern channels plus the frame word in the 8-lane/6-bit-per-lane parallel format the receive chain delivers on CLK. It can train, inject deliberate bit misalignment (slip) and inject single-bit errors, so the bitslip logic and the test-data checkers can be exercised end to end. It sits between the main CSR and the output serializers, or feeds the receive-side checkers directly in simulation.

## Interface
- No parameters.
- CLK  in  1  data clock, 125 MHz, same domain as the received ADC data.
- chk_rst  in  1  reset, asynchronous, active-high.
- enb  in  1  run enable, level.
- chk_type  in  4  test pattern number, same encoding the receive-side checkers use.
- slip  in  3  lane rotation in bits, 0–5; values 6 and 7 are treated as 0.
- err_inj  in  1  single-cycle error injection request.
- err_ch  in  2  channel that receives the injected error.
- DOUT  out  48  channel i on DOUT[12i+11:12i]; lane 2i = bits [5:0], lane 2i+1 = bits [11:6].
- FR  out  6  frame lane word.
- state  out  2  0 = IDLE, 1 = TRAIN, 2 = RUN.
- inj_cnt  out  16  count of errors actually injected.

## Operation
- **FSM.**
  - IDLE -> TRAIN when enb = 1.
  - TRAIN lasts exactly 16 CLK, then -> RUN.
  - Any state -> IDLE on the cycle after enb = 0.
- **Frame.** FR raw word = 6'b111000 in TRAIN and RUN, 6'b000000 in IDLE.
- **TRAIN data.** Every channel = 12'hFC0.
- **RUN patterns.** All four channels carry the same value.
  - 0: 0x000.
  - 1: 0x000.
  - 2: 0xFFF.
  - 3: alternate 0xAAA / 0x555, starting with 0xAAA.
  - 4: ramp; starts at 0x000, +1 per CLK, 0xFFF wraps to 0x000.
  - 5: constant 0x03F.
  - 6: PRBS (see Configuration).
  - 7–15: 0x000.
- **Pattern restart.** A change of chk_type during RUN restarts the pattern on the next word: ramp = 0, LFSR = seed, checkerboard phase = 0xAAA. Entering RUN also restarts the pattern.
- **Slip.** Applied per lane to all 9 lanes (8 data + frame). For each lane, W = {cur_raw, prev_raw}, 12 bits; out = W[s+5:s] with s = slip. prev_raw is that lane's raw word from the previous CLK. s = 0 gives out = cur_raw. A change of slip takes effect on the next word.
- **Error injection.**
  - When err_inj = 1 in RUN, bit 0 of channel err_ch is inverted in the next output word, after slip is applied.
  - Each injected error increments inj_cnt; inj_cnt saturates at 0xFFFF.
  - err_inj outside RUN is ignored and not counted.
  - Back-to-back pulses inject into consecutive words.

## Timing
- Reset values: DOUT = 0, FR = 0, state = IDLE, inj_cnt = 0. LFSR = seed, ramp = 0, prev_raw = 0.
- All outputs are registered.
- Output word reflects the state register of the same cycle: enb rising at edge n gives state = TRAIN after edge n+1, and the first TRAIN word on DOUT/FR after edge n+1.
- Latency from err_inj to the corrupted word: 1 CLK.
- chk_rst mid-operation returns everything to reset values immediately. Exit resumes from IDLE; with enb still high, TRAIN starts again.
- enb toggled during TRAIN restarts the full 16-cycle TRAIN on re-entry.

## Configuration
- Macro ADCEMU_PRBS_EN.
  - Defined: type 6 is a 12-bit Fibonacci LFSR x^12+x^6+x^4+x+1, seed 0xFFF, one step per CLK. The output value is the LFSR state.
  - Undefined: type 6 yields 0x000 and no LFSR logic is built.

## Structure
- Shared package holds:
  - pattern type constants (PAT_ZERO … PAT_PRBS);
  - FSM state encoding;
  - TRAIN_LEN = 16, FRAME_WORD = 6'b111000, TRAIN_WORD = 12'hFC0;
  - LFSR seed and taps.
- The checker's pattern table imports the same constants.
- One sub-module, adcemu_slip: one lane's 6-bit rotate with prev-word register. Instantiated 9 times.

## Test plan
- Reset with enb = 1: after release -> state = TRAIN for 16 CLK with DOUT = 48'hFC0FC0FC0FC0 and FR = 6'b111000, then RUN.
- RUN, chk_type = 4, slip = 0 -> each channel ramps 0x000, 0x001, …; after 4096 words it wraps to 0x000. A chk_type change to 3 restarts at 0xAAA.
- RUN, chk_type = 2, slip = 2 -> 0xFFF unaffected. FR sequence (prev 111000, cur 111000) -> 6'b001110 every word.
- RUN, chk_type = 5, two err_inj pulses with err_ch = 2 -> exactly two words have DOUT[35:24] = 0x03E, other channels untouched, inj_cnt = 2. A pulse in IDLE leaves inj_cnt = 2.
- With ADCEMU_PRBS_EN, chk_type = 6 -> first RUN word 0xFFF, sequence period 4095, never 0x000. Without the macro -> constant 0x000.
- chk_rst asserted mid-RUN -> DOUT, FR, inj_cnt = 0 on assertion; on release the TRAIN sequence repeats.
